// File: rtl/switch_bounce_pkg.sv
// Shared types and constants for the switch bounce generator.
`timescale 1ns/1ps

package switch_bounce_pkg;

    localparam int LFSR_W = 16;
    localparam int CNT_W  = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // One-hot encoding leaves spare codes, so corrupted states can be detected.
    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        BOUNCE = 2'b10
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// 16-bit right-shifting Galois LFSR; a zero seed is replaced by 1 so it never locks up.
`timescale 1ns/1ps

module lfsr16
    import switch_bounce_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= (seed == '0) ? LFSR_W'(1) : seed;
        end else begin
            r_q <= {1'b0, r_q[LFSR_W-1:1]} ^ (r_q[0] ? LFSR_TAPS : '0);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: clean level in, LFSR-timed contact bounce out.
// Optional feature macro: BOUNCE_STATS_EN (toggle counter on bounce_cnt).
`timescale 1ns/1ps

module switch_bounce_gen
    import switch_bounce_pkg::*;
#(
    parameter int                BOUNCE_WIN = 16,
    parameter int                MIN_GAP    = 1,
    parameter int                GAP_BITS   = 2,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             sw_clean,
    output logic             sw_noisy,
    output logic             busy,
    output logic [CNT_W-1:0] bounce_cnt
);

    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(BOUNCE_WIN - 1);

    state_t            r_state, w_state_nxt;
    logic              r_sw_q;
    logic              r_target, w_target_nxt;
    logic              r_sw_noisy, w_sw_noisy_nxt;
    logic [CNT_W-1:0]  r_win_cnt, w_win_nxt;
    logic [CNT_W-1:0]  r_gap_cnt, w_gap_nxt;
    logic              w_burst_start;
    logic [LFSR_W-1:0] w_lfsr;
    logic [CNT_W-1:0]  w_gap_load;
    logic              w_unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (w_lfsr)
    );

    assign w_gap_load    = CNT_W'(MIN_GAP) + CNT_W'(w_lfsr[GAP_BITS-1:0]);
    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:GAP_BITS];

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_sw_noisy_nxt = r_sw_noisy;
        w_win_nxt      = r_win_cnt;
        w_gap_nxt      = r_gap_cnt;
        w_burst_start  = 1'b0;
        case (r_state)
            IDLE, BOUNCE: begin
                if (r_sw_q != r_target) begin
                    // Input change (re)starts the burst regardless of tick.
                    w_target_nxt   = r_sw_q;
                    w_sw_noisy_nxt = ~r_sw_noisy;
                    w_win_nxt      = WIN_LOAD;
                    w_gap_nxt      = w_gap_load;
                    w_state_nxt    = BOUNCE;
                    w_burst_start  = 1'b1;
                end else if (r_state == IDLE) begin
                    w_sw_noisy_nxt = r_target;
                end else if (tick) begin
                    if (r_win_cnt == '0) begin
                        w_sw_noisy_nxt = r_target;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_win_nxt = r_win_cnt - 1'b1;
                        if (r_gap_cnt <= CNT_W'(1)) begin
                            w_sw_noisy_nxt = ~r_sw_noisy;
                            w_gap_nxt      = w_gap_load;
                        end else begin
                            w_gap_nxt = r_gap_cnt - 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_sw_noisy_nxt = r_target;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sw_q     <= 1'b0;
            r_target   <= 1'b0;
            r_sw_noisy <= 1'b0;
            r_win_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sw_q     <= sw_clean;
            r_target   <= w_target_nxt;
            r_sw_noisy <= w_sw_noisy_nxt;
            r_win_cnt  <= w_win_nxt;
            r_gap_cnt  <= w_gap_nxt;
        end
    end

    assign sw_noisy = r_sw_noisy;
    assign busy     = (r_state == BOUNCE);

`ifdef BOUNCE_STATS_EN
    logic [CNT_W-1:0] r_bounce_cnt;

    // Burst start counts its own first toggle; the forced final level only
    // counts when it actually moves sw_noisy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bounce_cnt <= '0;
        end else if (w_burst_start) begin
            r_bounce_cnt <= CNT_W'(1);
        end else if (w_sw_noisy_nxt != r_sw_noisy) begin
            r_bounce_cnt <= sat_inc(r_bounce_cnt);
        end
    end

    assign bounce_cnt = r_bounce_cnt;
`else
    assign bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Self-checking bench for switch_bounce_gen (default parameters).
`timescale 1ns/1ps

module tb_switch_bounce_gen;
    import switch_bounce_pkg::*;

`ifdef BOUNCE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b1;
    logic             sw_clean = 1'b0;
    logic             sw_noisy;
    logic             busy;
    logic [CNT_W-1:0] bounce_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    switch_bounce_gen dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .sw_clean   (sw_clean),
        .sw_noisy   (sw_noisy),
        .busy       (busy),
        .bounce_cnt (bounce_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Follows a burst from just after its first toggle until busy drops.
    // units counts ticks (every clock when div4=0); gaps are in the same units.
    task automatic track_burst(input bit div4, input int max_cyc,
                               output int units, output int toggles,
                               output int gmin, output int gmax, output int bad);
        logic prev;
        int   since;
        int   phase;
        bit   tk;
        prev = sw_noisy; toggles = 1; units = 0; since = 0;
        gmin = 99; gmax = 0; bad = 0; phase = 0;
        for (int c = 0; c < max_cyc && busy === 1'b1; c++) begin
            tk    = div4 ? (phase == 3) : 1'b1;
            phase = (phase + 1) % 4;
            tick  = tk;
            cyc();
            if (tk) begin
                units++;
                since++;
            end
            if (sw_noisy !== prev) begin
                if (!tk) bad++;
                toggles++;
                if (since < gmin) gmin = since;
                if (since > gmax) gmax = since;
                since = 0;
                prev  = sw_noisy;
            end
        end
        tick = 1'b1;
    endtask

    task automatic settle(input string name);
        tick = 1'b1;
        cyc();
        cyc();
        for (int c = 0; c < 60 && busy === 1'b1; c++) cyc();
        check({name, " busy"}, busy, 0);
        check({name, " level"}, sw_noisy, sw_clean);
    endtask

    task automatic record(output logic [31:0] w);
        reset = 1'b1; sw_clean = 1'b0; tick = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        sw_clean = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cyc();
            w[i] = sw_noisy;
        end
    endtask

    typedef struct {
        logic             rst;
        logic             tk;
        logic             sw;
        logic             noisy;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int units, tog, gmin, gmax, bad, chg;
        logic prev;
        logic [31:0] w1, w2;

        // rst, tick, sw_clean -> sw_noisy, busy, bounce_cnt (after the edge)
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 14; i++) begin
            reset    = vecs[i].rst;
            tick     = vecs[i].tk;
            sw_clean = vecs[i].sw;
            cyc();
            check($sformatf("vec%0d sw_noisy", i), sw_noisy, vecs[i].noisy);
            check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d bounce_cnt", i), bounce_cnt, exp_cnt(int'(vecs[i].cnt)));
        end

        // Rising edge, tick every cycle: full 16-cycle window, final level 1.
        tick = 1'b1;
        sw_clean = 1'b1;
        cyc();
        check("A sync stage", sw_noisy, 0);
        cyc();
        check("A first toggle", sw_noisy, 1);
        check("A busy", busy, 1);
        track_burst(1'b0, 40, units, tog, gmin, gmax, bad);
        check("A window cycles", units, 16);
        check("A busy end", busy, 0);
        check("A final level", sw_noisy, 1);
        check("A gap min in range", (gmin >= 1 && gmin <= 4), 1);
        check("A gap max in range", (gmax >= 1 && gmax <= 4), 1);
        check("A bounce_cnt", bounce_cnt, exp_cnt(tog));
        chg = 0;
        prev = sw_noisy;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (sw_noisy !== prev || busy !== 1'b0) chg++;
        end
        check("A quiet after window", chg, 0);
        sw_clean = 1'b0;
        settle("A settle");

        // Reversal at cycle 5 of a rising burst restarts the window.
        sw_clean = 1'b1;
        cyc();
        cyc();
        check("C first toggle", sw_noisy, 1);
        repeat (5) cyc();
        sw_clean = 1'b0;
        cyc();
        prev = sw_noisy;
        cyc();
        check("C restart toggle", (sw_noisy !== prev), 1);
        check("C busy", busy, 1);
        check("C restart bounce_cnt", bounce_cnt, exp_cnt(1));
        track_burst(1'b0, 40, units, tog, gmin, gmax, bad);
        check("C window cycles", units, 16);
        check("C final level", sw_noisy, 0);
        check("C busy end", busy, 0);
        check("C bounce_cnt", bounce_cnt, exp_cnt(tog));

        // Tick 1-of-4: window and gaps measured in ticks, toggles only on ticks.
        tick = 1'b0;
        sw_clean = 1'b1;
        cyc();
        cyc();
        check("B first toggle without tick", sw_noisy, 1);
        track_burst(1'b1, 200, units, tog, gmin, gmax, bad);
        check("B window ticks", units, 16);
        check("B toggles off tick", bad, 0);
        check("B gap min in range", (gmin >= 1 && gmin <= 4), 1);
        check("B gap max in range", (gmax >= 1 && gmax <= 4), 1);
        check("B final level", sw_noisy, 1);
        check("B bounce_cnt", bounce_cnt, exp_cnt(tog));
        sw_clean = 1'b0;
        settle("B settle");

        // Reset at cycle 8 of a burst.
        sw_clean = 1'b1;
        cyc();
        cyc();
        repeat (7) cyc();
        check("D busy before reset", busy, 1);
        reset = 1'b1;
        cyc();
        check("D reset sw_noisy", sw_noisy, 0);
        check("D reset busy", busy, 0);
        check("D reset bounce_cnt", bounce_cnt, 0);
        reset = 1'b0;
        sw_clean = 1'b0;
        repeat (3) cyc();
        check("D idle after reset", busy, 0);

        // Same seed after reset replays the same waveform.
        record(w1);
        record(w2);
        check("R first toggle timing", w1[1:0], 2'b10);
        check("R settled high", w1[31:17], 15'h7FFF);
        check("R replay identical", w2, w1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
